me_result_sequencer: RTL and testbench
======================================

// Module: me_result_sequencer
// PURPOSE
//  Downstream control/collect stage for the motion estimation core (top).
//  Launches the core once per macroblock via start. Captures BestDist/motionX/motionY
//  when completed rises, tags each result with a block index and queues it in a FIFO
//  drained by a valid/ready consumer. Tracks the batch minimum distance.
// PARAMETERS
//  DIST_W   8   width of BestDist / out_dist / min_dist
//  MV_W     4   width of motionX/motionY (two's complement)
//  TAG_W    8   width of block index tag and num_blocks
//  DEPTH    4   FIFO entries (power of 2, >=2)
//  GAP_CYC  2   cycles start is held low between launches (>=2)
// PORTS
//  clock       in   1       system clock, all state on rising edge
//  reset_n     in   1       asynchronous active-low reset
//  go          in   1       1-cycle pulse: begin batch (ignored unless IDLE)
//  num_blocks  in   TAG_W   blocks in batch, sampled on go; 0 = batch ends immediately
//  start       out  1       to core start; high while a block is running
//  completed   in   1       from core; level, may stay high until start drops
//  BestDist    in   DIST_W  from core, valid when completed high
//  motionX     in   MV_W    from core
//  motionY     in   MV_W    from core
//  out_valid   out  1       FIFO head valid
//  out_ready   in   1       consumer accepts head when out_valid&&out_ready
//  out_dist    out  DIST_W  head distance
//  out_mvx     out  MV_W    head motion X
//  out_mvy     out  MV_W    head motion Y
//  out_tag     out  TAG_W   head block index (0..num_blocks-1)
//  min_dist    out  DIST_W  smallest BestDist captured this batch
//  min_tag     out  TAG_W   tag of min_dist (first occurrence wins ties)
//  busy        out  1       high in any state but IDLE
//  batch_done  out  1       1-cycle pulse on return to IDLE after a batch
// BEHAVIOUR
//  Reset: all outputs 0 except min_dist = all ones. FSM = IDLE, FIFO empty, tag counter = 0.
//  Reset mid-batch aborts immediately. FIFO contents are lost, and start drops asynchronously.
//  FSM states: IDLE, LAUNCH, ARM, RUN, CAPTURE, GAP.
//   IDLE: start=0. On go: load remaining=num_blocks, tag=0, min_dist=all ones.
//         Then GAP if num_blocks!=0, else pulse batch_done and stay in IDLE.
//   GAP: start=0 for GAP_CYC cycles. Then LAUNCH if remaining!=0, else IDLE with batch_done.
//   LAUNCH: go to ARM only when FIFO is not full. Otherwise hold here with start=0.
//           This stalls the batch and means a capture never finds the FIFO full.
//   ARM: start=1. Wait for completed==0 so a stale level from the previous block is ignored.
//        Go to RUN once completed is seen low.
//   RUN: start=1. Go to CAPTURE on the first cycle completed==1.
//   CAPTURE: start=1. Push {BestDist,motionX,motionY,tag}, sampled this cycle.
//            If BestDist<min_dist, update min_dist/min_tag.
//            Then tag+=1 (wraps mod 2^TAG_W), remaining-=1, and go to GAP.
//  Latency: completed rising -> result pushed at the end of the next cycle.
//           out_valid is high in the cycle after the push (registered FIFO head).
//  FIFO: first-word fall-through registered head. out_* is stable while out_valid&&!out_ready.
//   A push and a pop in the same cycle leaves count unchanged.
//   A pop on empty is ignored, and out_* hold their last values.
//   Read/write pointers wrap mod DEPTH. Count is a separate log2(DEPTH)+1 bit register.
//  go outside IDLE is ignored with no effect. out_ready is independent of FSM state.
//   The FIFO drains after batch_done.
//  min_dist/min_tag hold their values after the batch until the next go.
//   A tie (equal distance) does not update min_tag.
//  BestDist/motion inputs are not sampled outside CAPTURE.
// TESTING
//  1. Reset then go with num_blocks=1; core returns Dist=0x12,X=-3,Y=2.
//     -> start high, one entry {0x12,4'hD,4'h2,tag 0}, min_dist=0x12, batch_done one cycle.
//  2. num_blocks=3 with dists 0x40,0x10,0x10, out_ready=1.
//     -> tags 0,1,2 in order; min_dist=0x10, min_tag=1; start low >=2 cycles between blocks.
//  3. DEPTH=4, num_blocks=6, out_ready=0 -> 4 entries; FSM stalls in LAUNCH, start=0.
//     Then raise out_ready -> remaining 2 blocks run, all 6 results are seen in order.
//  4. Hold completed high from the previous block into a new launch.
//     -> no capture until completed goes low and then high again (ARM filter).
//  5. go with num_blocks=0 -> batch_done on the next cycle, no start, FIFO empty.
//     A go pulse while busy -> ignored.
//  6. Assert reset_n=0 while in RUN with 2 entries queued.
//     -> start=0, out_valid=0, busy=0, min_dist=0xFF immediately; a new go works normally.

Source files
------------

// File: rtl/me_result_sequencer.sv
// Control/collect stage for the motion estimation core: launches one core run per
// macroblock, queues tagged results in a FWFT FIFO and tracks the batch minimum.
module me_result_sequencer #(
  parameter int unsigned DIST_W  = 8,
  parameter int unsigned MV_W    = 4,
  parameter int unsigned TAG_W   = 8,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned GAP_CYC = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              go,
  input  logic [TAG_W-1:0]  num_blocks,
  output logic              start,
  input  logic              completed,
  input  logic [DIST_W-1:0] BestDist,
  input  logic [MV_W-1:0]   motionX,
  input  logic [MV_W-1:0]   motionY,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DIST_W-1:0] out_dist,
  output logic [MV_W-1:0]   out_mvx,
  output logic [MV_W-1:0]   out_mvy,
  output logic [TAG_W-1:0]  out_tag,
  output logic [DIST_W-1:0] min_dist,
  output logic [TAG_W-1:0]  min_tag,
  output logic              busy,
  output logic              batch_done
);

  localparam int unsigned PW      = $clog2(DEPTH);
  localparam int unsigned CW      = PW + 1;
  localparam int unsigned GW      = $clog2(GAP_CYC);
  localparam int unsigned ENTRY_W = DIST_W + 2 * MV_W + TAG_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_ARM,
    S_RUN,
    S_CAPTURE,
    S_GAP
  } state_t;

  state_t              state;
  logic [TAG_W-1:0]    remaining;
  logic [TAG_W-1:0]    tag;
  logic [GW-1:0]       gap_cnt;

  logic [ENTRY_W-1:0]  mem [DEPTH];
  logic [ENTRY_W-1:0]  head;
  logic [ENTRY_W-1:0]  wdata;
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [CW-1:0]       count;
  logic                push;
  logic                pop;
  logic                full;

  assign push      = (state == S_CAPTURE);
  assign pop       = out_valid && out_ready;
  assign full      = (count == CW'(DEPTH));
  assign out_valid = (count != '0);
  assign wdata     = {BestDist, motionX, motionY, tag};
  assign {out_dist, out_mvx, out_mvy, out_tag} = head;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      start      <= 1'b0;
      busy       <= 1'b0;
      batch_done <= 1'b0;
      remaining  <= '0;
      tag        <= '0;
      gap_cnt    <= '0;
      min_dist   <= '1;
      min_tag    <= '0;
    end else begin
      batch_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (go) begin
            remaining <= num_blocks;
            tag       <= '0;
            min_dist  <= '1;
            min_tag   <= '0;
            if (num_blocks != '0) begin
              state   <= S_GAP;
              gap_cnt <= GW'(GAP_CYC - 1);
              busy    <= 1'b1;
            end else begin
              batch_done <= 1'b1;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == '0) begin
            if (remaining != '0) begin
              state <= S_LAUNCH;
            end else begin
              state      <= S_IDLE;
              busy       <= 1'b0;
              batch_done <= 1'b1;
            end
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        // Holding here while full guarantees every later capture has a free slot.
        S_LAUNCH: begin
          if (!full) begin
            state <= S_ARM;
            start <= 1'b1;
          end
        end
        S_ARM: begin
          if (!completed) state <= S_RUN;
        end
        S_RUN: begin
          if (completed) state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          if (BestDist < min_dist) begin
            min_dist <= BestDist;
            min_tag  <= tag;
          end
          tag       <= tag + 1'b1;
          remaining <= remaining - 1'b1;
          start     <= 1'b0;
          state     <= S_GAP;
          gap_cnt   <= GW'(GAP_CYC - 1);
        end
        default: begin
          state <= S_IDLE;
          start <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // The head register only changes on pop or on push-into-empty, so it holds its
  // last value when the FIFO runs dry.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      if (pop) begin
        if (count > CW'(1)) head <= mem[rd_ptr + PW'(1)];
        else if (push)      head <= wdata;
      end else if (push && count == '0) begin
        head <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_me_result_sequencer.sv
// Randomized bench for me_result_sequencer: a core model issues results, a queue
// model predicts the FIFO stream and batch minimum, and a compare process checks them.
module tb_me_result_sequencer;

  localparam int DIST_W  = 8;
  localparam int MV_W    = 4;
  localparam int TAG_W   = 8;
  localparam int DEPTH   = 4;
  localparam int GAP_CYC = 2;

  typedef struct packed {
    logic [7:0] d;
    logic [3:0] x;
    logic [3:0] y;
    logic [7:0] t;
  } res_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        go = 1'b0;
  logic [7:0]  num_blocks = '0;
  logic        start;
  logic        completed = 1'b0;
  logic [7:0]  BestDist = '0;
  logic [3:0]  motionX = '0;
  logic [3:0]  motionY = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_dist;
  logic [3:0]  out_mvx;
  logic [3:0]  out_mvy;
  logic [7:0]  out_tag;
  logic [7:0]  min_dist;
  logic [7:0]  min_tag;
  logic        busy;
  logic        batch_done;

  me_result_sequencer #(
    .DIST_W(DIST_W), .MV_W(MV_W), .TAG_W(TAG_W), .DEPTH(DEPTH), .GAP_CYC(GAP_CYC)
  ) u_dut (
    .clock(clock), .reset_n(reset_n), .go(go), .num_blocks(num_blocks),
    .start(start), .completed(completed), .BestDist(BestDist),
    .motionX(motionX), .motionY(motionY), .out_valid(out_valid),
    .out_ready(out_ready), .out_dist(out_dist), .out_mvx(out_mvx),
    .out_mvy(out_mvy), .out_tag(out_tag), .min_dist(min_dist),
    .min_tag(min_tag), .busy(busy), .batch_done(batch_done)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model state
  res_t       exp_q[$];
  res_t       forced_q[$];
  logic [7:0] m_min = 8'hFF;
  logic [7:0] m_min_tag = '0;
  logic [7:0] m_next_tag = '0;
  int         m_blocks = 0;
  int         m_issued_batch = 0;
  int         batches_done = 0;
  int         starts_seen = 0;
  int         gap_low = 0;

  // Core model knobs
  int core_lat = 2;
  int stale_cfg = 0;
  bit rand_ready = 0;

  // Core model: responds core_lat cycles after seeing start, holds completed
  // for stale_cfg cycles past the end of its run.
  initial begin
    res_t r;
    bit   issued;
    int   cnt;
    int   stale;
    issued = 0; cnt = 0; stale = 0;
    forever begin
      @(posedge clock); #1;
      if (!reset_n) begin
        completed = 1'b0; issued = 0; cnt = 0; stale = 0;
      end else if (!start) begin
        cnt = 0; issued = 0;
        if (completed) begin
          if (stale == 0) begin completed = 1'b0; BestDist = 8'($urandom); end
          else stale--;
        end
      end else begin
        cnt++;
        if (completed && !issued) begin
          if (stale == 0) begin completed = 1'b0; BestDist = 8'($urandom); end
          else stale--;
        end else if (!completed && !issued && cnt >= core_lat + 1) begin
          if (forced_q.size() > 0) r = forced_q.pop_front();
          else begin
            r.d = 8'($urandom_range(0, 254));
            r.x = 4'($urandom);
            r.y = 4'($urandom);
          end
          r.t = m_next_tag;
          BestDist = r.d; motionX = r.x; motionY = r.y;
          completed = 1'b1; issued = 1; stale = stale_cfg;
          exp_q.push_back(r);
          if (r.d < m_min) begin m_min = r.d; m_min_tag = m_next_tag; end
          m_next_tag = m_next_tag + 8'd1;
          m_issued_batch++;
        end
      end
    end
  end

  // Compare process
  bit   chk_en = 0;
  bit   prev_hold = 0;
  logic [23:0] prev_head = '0;
  logic prev_start = 0;
  logic prev_bd = 0;
  always @(negedge clock) begin
    res_t e;
    if (!reset_n) begin
      prev_hold = 0; prev_start = 0; prev_bd = 0; gap_low = 0;
    end else if (chk_en) begin
      if (prev_hold)
        chk("hold_stable", {7'd0, out_valid, out_dist, out_mvx, out_mvy, out_tag}, {7'd0, 1'b1, prev_head});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("spurious_entry", {8'd0, out_dist, out_mvx, out_mvy, out_tag}, 32'hFFFFFFFF);
        else begin
          e = exp_q.pop_front();
          chk("out_entry", {8'd0, out_dist, out_mvx, out_mvy, out_tag}, {8'd0, e});
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_head = {out_dist, out_mvx, out_mvy, out_tag};
      if (start && !prev_start) begin
        starts_seen++;
        if (starts_seen > 1) chk("gap_len", (gap_low >= GAP_CYC) ? 32'd1 : 32'd0, 32'd1);
      end
      if (!start) gap_low++; else gap_low = 0;
      if (batch_done) begin
        chk("batch_done_pulse", {31'd0, prev_bd}, 32'd0);
        chk("min_dist", {24'd0, min_dist}, {24'd0, m_min});
        chk("min_tag", {24'd0, min_tag}, {24'd0, m_min_tag});
        chk("blocks_run", starts_seen, m_blocks);
        chk("busy_after_done", {31'd0, busy}, 32'd0);
        batches_done++;
      end
      prev_start = start;
      prev_bd = batch_done;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock); #2;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic start_batch(input int n);
    num_blocks = 8'(n); go = 1'b1;
    m_blocks = n; m_min = 8'hFF; m_min_tag = '0; m_next_tag = '0;
    m_issued_batch = 0; starts_seen = 0;
    tick(1);
    go = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int target = batches_done + 1;
    int i = 0;
    while (batches_done < target && i < limit) begin tick(1); i++; end
    if (batches_done < target) chk("batch_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drain();
    int i = 0;
    rand_ready = 0; out_ready = 1'b1;
    while (exp_q.size() != 0 && i < 500) begin tick(1); i++; end
    chk("drain_model_empty", exp_q.size(), 0);
    chk("drain_out_valid", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int i;
    int lat;
    res_t f;
    tick(2);
    chk("rst_start", {31'd0, start}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_batch_done", {31'd0, batch_done}, 32'd0);
    chk("rst_min_dist", {24'd0, min_dist}, 32'hFF);
    chk("rst_min_tag", {24'd0, min_tag}, 32'h0);
    chk("rst_head", {8'd0, out_dist, out_mvx, out_mvy, out_tag}, 32'h0);
    reset_n = 1'b1;
    chk_en = 1;
    tick(2);

    // 1: single block, literal result and latency
    f = '{d: 8'h12, x: 4'hD, y: 4'h2, t: 8'h00};
    forced_q.push_back(f);
    core_lat = 2; stale_cfg = 0; out_ready = 1'b0;
    start_batch(1);
    i = 0;
    while (!completed && i < 50) begin tick(1); i++; end
    chk("t1_start_high", {31'd0, start}, 32'd1);
    lat = 0;
    while (!out_valid && lat < 10) begin tick(1); lat++; end
    chk("t1_latency", lat, 2);
    chk("t1_entry", {8'd0, out_dist, out_mvx, out_mvy, out_tag}, 32'h0012D200);
    out_ready = 1'b1;
    wait_done(200);
    chk("t1_min_dist", {24'd0, min_dist}, 32'h12);
    wait_drain();

    // 2: three blocks, tie on minimum keeps first tag
    forced_q.push_back('{d: 8'h40, x: 4'h1, y: 4'hF, t: 8'h0});
    forced_q.push_back('{d: 8'h10, x: 4'h7, y: 4'h8, t: 8'h0});
    forced_q.push_back('{d: 8'h10, x: 4'h9, y: 4'h3, t: 8'h0});
    start_batch(3);
    wait_done(300);
    chk("t2_min_dist", {24'd0, min_dist}, 32'h10);
    chk("t2_min_tag", {24'd0, min_tag}, 32'h1);
    wait_drain();

    // 3: FIFO fills, FSM stalls with start low
    out_ready = 1'b0;
    start_batch(6);
    i = 0;
    while (m_issued_batch < 4 && i < 300) begin tick(1); i++; end
    tick(20);
    chk("t3_stall_start", {31'd0, start}, 32'd0);
    chk("t3_stall_busy", {31'd0, busy}, 32'd1);
    chk("t3_stall_issued", m_issued_batch, 4);
    chk("t3_stall_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    wait_done(500);
    wait_drain();

    // 4: completed held high into the next launch
    core_lat = 1; stale_cfg = 6;
    start_batch(3);
    wait_done(500);
    wait_drain();
    stale_cfg = 0;

    // 5: empty batch, then go while busy
    start_batch(0);
    chk("t5_done", {31'd0, batch_done}, 32'd1);
    chk("t5_start", {31'd0, start}, 32'd0);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_valid", {31'd0, out_valid}, 32'd0);
    tick(2);
    start_batch(2);
    tick(3);
    num_blocks = 8'd5; go = 1'b1;
    tick(1);
    go = 1'b0;
    wait_done(500);
    wait_drain();

    // 6: reset in RUN with two entries queued
    out_ready = 1'b0; core_lat = 8;
    start_batch(5);
    i = 0;
    while (m_issued_batch < 2 && i < 300) begin tick(1); i++; end
    i = 0;
    while (start && i < 50) begin tick(1); i++; end
    i = 0;
    while (!start && i < 50) begin tick(1); i++; end
    tick(3);
    chk("t6_pre_valid", {31'd0, out_valid}, 32'd1);
    chk("t6_pre_start", {31'd0, start}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("t6_start", {31'd0, start}, 32'd0);
    chk("t6_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_min_dist", {24'd0, min_dist}, 32'hFF);
    exp_q.delete();
    tick(2);
    reset_n = 1'b1;
    tick(2);

    // Random batches with random ready, latency and stale hold
    for (int b = 0; b < 12; b++) begin
      core_lat = $urandom_range(1, 4);
      stale_cfg = $urandom_range(0, 5);
      rand_ready = 1;
      start_batch($urandom_range(1, 8));
      wait_done(3000);
      wait_drain();
    end

    chk("final_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
